// File: rtl/test_sequencer_pkg.sv
// Shared constants and types for the test sequencer: state encoding macros,
// the default timeout, and the typed state enum built from them.
`ifndef TEST_SEQUENCER_DEFS
`define TEST_SEQUENCER_DEFS
`define TS_ST_IDLE         2'd0
`define TS_ST_WAIT         2'd1
`define TS_ST_GAP          2'd2
`define TS_ST_DONE         2'd3
`define TS_TIMEOUT_DEFAULT 1000
`endif

package test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `TS_ST_IDLE,
        ST_WAIT = `TS_ST_WAIT,
        ST_GAP  = `TS_ST_GAP,
        ST_DONE = `TS_ST_DONE
    } state_t;

    localparam int DEF_TIMEOUT = `TS_TIMEOUT_DEFAULT;

    // Cycles between a finish edge and the FSM acting on it.
    localparam int SYNC_LAT = 2;

endpackage

// File: rtl/test_sequencer_sync_2ff.sv
// Two-flop synchronizer for a vector of independent asynchronous flags.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture the asynchronous input, then re-register to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Launches NUM_TESTS test modules one at a time, waits for each sticky finish
// with a timeout, and records pass / timeout / stale-finish per test.
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int CNT_W          = 16,
    parameter int IDX_W          = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [NUM_TESTS-1:0] finish,
    output logic [NUM_TESTS-1:0] start,
    output logic [IDX_W-1:0]     cur_test,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic [NUM_TESTS-1:0] stale_mask
);

    localparam logic [NUM_TESTS-1:0] FIRST_SEL = NUM_TESTS'(1);
    localparam logic [CNT_W-1:0]     LIMIT     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_TESTS - 1);

    logic [NUM_TESTS-1:0] fs;
    logic [NUM_TESTS-1:0] cur_sel;
    logic                 fs_cur;
    logic                 at_limit;
    logic                 last_test;
    logic [CNT_W-1:0]     count;
    state_t               state;

    sync_2ff #(
        .WIDTH(NUM_TESTS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (finish),
        .q   (fs)
    );

    // One-hot select of the current test; other finish bits are masked out.
    always_comb begin
        cur_sel = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            if (cur_test == IDX_W'(i)) cur_sel[i] = 1'b1;
        end
    end

    assign fs_cur    = |(fs & cur_sel);
    assign at_limit  = (count == LIMIT);
    assign last_test = (cur_test == LAST_IDX);

    // Sequencing FSM; every output is registered and changes only on transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            start        <= '0;
            cur_test     <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            stale_mask   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state        <= ST_WAIT;
                        start        <= FIRST_SEL;
                        cur_test     <= '0;
                        count        <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass_mask    <= '0;
                        timeout_mask <= '0;
                        stale_mask   <= '0;
                    end
                end
                ST_WAIT: begin
                    // A finish seen on the timeout cycle still counts as a pass.
                    if (fs_cur) begin
                        pass_mask <= pass_mask | cur_sel;
                        if (count == '0) stale_mask <= stale_mask | cur_sel;
                        start <= '0;
                        state <= ST_GAP;
                    end else if (at_limit) begin
                        timeout_mask <= timeout_mask | cur_sel;
                        start        <= '0;
                        state        <= ST_GAP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_GAP: begin
                    // One all-low cycle so the next test sees a clean rising edge.
                    if (last_test) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cur_test <= cur_test + 1'b1;
                        start    <= cur_sel << 1;
                        count    <= '0;
                        state    <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: emulated test modules driven by per-test modes,
// table rows, randomized runs against a rule-level model, and corner sequences.
module tb_test_sequencer;

    localparam int N        = 4;
    localparam int TO       = 20;
    localparam int IW       = 2;
    localparam int LAT      = 2;   // synchronizer latency
    localparam int NEVER    = -1;
    localparam int TIED     = -2;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [N-1:0]  finish;
    logic [N-1:0]  start;
    logic [IW-1:0] cur_test;
    logic          busy;
    logic          done;
    logic [N-1:0]  pass_mask;
    logic [N-1:0]  timeout_mask;
    logic [N-1:0]  stale_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_sequencer #(
        .NUM_TESTS(N), .TIMEOUT_CYCLES(TO), .CNT_W(16), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .finish(finish), .start(start),
        .cur_test(cur_test), .busy(busy), .done(done), .pass_mask(pass_mask),
        .timeout_mask(timeout_mask), .stale_mask(stale_mask)
    );

    // Test-module emulation: mode[i] >= 0 means finish rises that many cycles
    // after start[i] rises; NEVER never finishes; TIED is high all the time.
    int           mode [N];
    logic [N-1:0] fin_reg = '0;
    logic [N-1:0] tied_mask;
    logic         clear_fin = 1'b0;

    always_comb begin
        tied_mask = '0;
        for (int i = 0; i < N; i++) if (mode[i] == TIED) tied_mask[i] = 1'b1;
        finish = fin_reg | tied_mask;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           rise_cyc [N];
    int           fall_cyc [N];
    int           hi_len   [N];
    int           rise_cnt [N];
    int           multi_cnt = 0;
    logic [N-1:0] prev_start = '0;

    // Observe start edges and raise finish bits according to each mode.
    always @(negedge clk) begin
        if (clear_fin) fin_reg = '0;
        for (int i = 0; i < N; i++) begin
            if (start[i] && !prev_start[i]) begin
                rise_cyc[i] = cyc;
                rise_cnt[i] = rise_cnt[i] + 1;
            end
            if (!start[i] && prev_start[i]) begin
                fall_cyc[i] = cyc;
                hi_len[i]   = cyc - rise_cyc[i];
            end
            if (start[i] && mode[i] >= 0 && (cyc - rise_cyc[i]) == mode[i])
                fin_reg[i] = 1'b1;
        end
        if ($countones(start) > 1) multi_cnt = multi_cnt + 1;
        prev_start = start;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: finish becomes visible LAT cycles after it rises;
    // it passes if visible within the TO-cycle window, stale if already high.
    logic [N-1:0] ep, et, es;
    int           exp_len [N];

    task automatic model();
        ep = '0; et = '0; es = '0;
        for (int i = 0; i < N; i++) begin
            if (mode[i] == TIED) begin
                ep[i] = 1'b1; es[i] = 1'b1; exp_len[i] = 1;
            end else if (mode[i] >= 0 && mode[i] + LAT < TO) begin
                ep[i] = 1'b1; exp_len[i] = mode[i] + LAT + 1;
            end else begin
                et[i] = 1'b1; exp_len[i] = TO;
            end
        end
    endtask

    task automatic set_modes(input int a, input int b, input int c, input int d);
        mode[0] = a; mode[1] = b; mode[2] = c; mode[3] = d;
    endtask

    task automatic clear_finishes();
        @(posedge clk); #1 clear_fin = 1'b1;
        @(posedge clk); #1 clear_fin = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_test(input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy && cur_test == IW'(k) && start[k]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Full run from IDLE/DONE with expected masks supplied by the caller.
    task automatic do_run(input logic [N-1:0] wp, input logic [N-1:0] wt, input logic [N-1:0] ws);
        int base_rise [N];
        int base_multi;
        bit ok;
        model();
        clear_finishes();
        for (int i = 0; i < N; i++) base_rise[i] = rise_cnt[i];
        base_multi = multi_cnt;
        pulse_go();
        chk("launch_start", 32'(start), 32'(4'b0001));
        chk("launch_busy", 32'(busy), 32'd1);
        wait_done(ok);
        chk("done_reached", 32'(ok), 32'd1);
        chk("pass_mask", 32'(pass_mask), 32'(wp));
        chk("timeout_mask", 32'(timeout_mask), 32'(wt));
        chk("stale_mask", 32'(stale_mask), 32'(ws));
        chk("final_cur_test", 32'(cur_test), 32'(N - 1));
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_start", 32'(start), 32'd0);
        for (int i = 0; i < N; i++) begin
            chk("start_rises", 32'(rise_cnt[i] - base_rise[i]), 32'd1);
            chk("start_high_len", 32'(hi_len[i]), 32'(exp_len[i]));
        end
        for (int i = 0; i < N - 1; i++)
            chk("gap_len", 32'(rise_cyc[i+1] - fall_cyc[i]), 32'd1);
        chk("start_onehot", 32'(multi_cnt - base_multi), 32'd0);
    endtask

    typedef struct {
        int           md [N];
        logic [N-1:0] p;
        logic [N-1:0] t;
        logic [N-1:0] s;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit ok;

        tbl[0].md = '{5, 5, 5, 5};         tbl[0].p = 4'b1111; tbl[0].t = 4'b0000; tbl[0].s = 4'b0000;
        tbl[1].md = '{5, 5, NEVER, 5};     tbl[1].p = 4'b1011; tbl[1].t = 4'b0100; tbl[1].s = 4'b0000;
        tbl[2].md = '{5, TIED, 5, 5};      tbl[2].p = 4'b1111; tbl[2].t = 4'b0000; tbl[2].s = 4'b0010;
        tbl[3].md = '{17, 5, 5, 5};        tbl[3].p = 4'b1111; tbl[3].t = 4'b0000; tbl[3].s = 4'b0000;
        tbl[4].md = '{18, 5, 5, 5};        tbl[4].p = 4'b1110; tbl[4].t = 4'b0001; tbl[4].s = 4'b0000;
        tbl[5].md = '{0, NEVER, NEVER, 0}; tbl[5].p = 4'b1001; tbl[5].t = 4'b0110; tbl[5].s = 4'b0000;

        for (int i = 0; i < N; i++) begin
            rise_cyc[i] = 0; fall_cyc[i] = 0; hi_len[i] = 0; rise_cnt[i] = 0;
        end
        set_modes(NEVER, NEVER, NEVER, NEVER);
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset_masks", 32'({pass_mask, timeout_mask, stale_mask}), 32'd0);
        chk("reset_cur_test", 32'(cur_test), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_start", 32'(start), 32'd0);

        // Table rows with hand-derived expected masks.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) mode[i] = tbl[r].md[i];
            do_run(tbl[r].p, tbl[r].t, tbl[r].s);
        end

        // Randomized runs checked against the model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 9))
                    0:       mode[i] = NEVER;
                    1:       mode[i] = TIED;
                    default: mode[i] = int'($urandom_range(0, 22));
                endcase
            end
            model();
            do_run(ep, et, es);
        end

        // Reset in the middle of test 1 discards results and drops start at once.
        set_modes(2, NEVER, 5, 5);
        clear_finishes();
        pulse_go();
        wait_test(1, ok);
        chk("reach_test1", 32'(ok), 32'd1);
        chk("pre_reset_pass", 32'(pass_mask), 32'(4'b0001));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_start", 32'(start), 32'd0);
        chk("async_masks", 32'({pass_mask, timeout_mask, stale_mask}), 32'd0);
        chk("async_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_modes(3, 3, 3, 3);
        do_run(4'b1111, 4'b0000, 4'b0000);

        // go while busy is ignored; go in DONE restarts and clears masks.
        begin
            int base0;
            set_modes(5, 5, 5, 5);
            clear_finishes();
            base0 = rise_cnt[0];
            pulse_go();
            wait_test(2, ok);
            chk("reach_test2", 32'(ok), 32'd1);
            pulse_go();
            chk("busy_go_cur", 32'(cur_test), 32'd2);
            wait_done(ok);
            chk("busy_go_done", 32'(ok), 32'd1);
            chk("busy_go_rises", 32'(rise_cnt[0] - base0), 32'd1);
            chk("busy_go_pass", 32'(pass_mask), 32'(4'b1111));
            set_modes(NEVER, 5, 5, 5);
            clear_finishes();
            chk("done_hold", {31'd0, done}, 32'd1);
            chk("done_hold_pass", 32'(pass_mask), 32'(4'b1111));
            pulse_go();
            chk("restart_done", {31'd0, done}, 32'd0);
            chk("restart_start", 32'(start), 32'(4'b0001));
            chk("restart_masks", 32'({pass_mask, timeout_mask, stale_mask}), 32'd0);
            chk("restart_cur", 32'(cur_test), 32'd0);
            wait_done(ok);
            chk("restart_finish", 32'(ok), 32'd1);
            chk("restart_timeout", 32'(timeout_mask), 32'(4'b0001));
            chk("restart_pass", 32'(pass_mask), 32'(4'b1110));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
